alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have no parameters; beat count is fixed at 8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to run one ALU operation; sampled only when busy=0.
REQ-005 opcode  input  4  0 MOV, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 OR, 6 NOT, 7 AND, 8 XOR, 9 SHL, 10 SHR, 11-15 illegal.
REQ-006 stall  input  1  freezes the beat ring while high.
REQ-007 b_zero  input  1  divisor-is-zero flag from the B latch; meaningful in beat T[3].
REQ-008 t  output  8  one-hot beat vector T[7:0] to the ALU.
REQ-009 iop  output  11  one-hot op select: bit n = opcode n (IMOV..ISHR in opcode order).
REQ-010 ealu  output  1  ALU output enable onto the bus.
REQ-011 we_lo / we_hi  output  1 each  destination write strobes for low / high result byte.
REQ-012 busy, done, err  output  1 each  operation in flight; completion pulse; error pulse.

Function
REQ-013 States SHALL be IDLE, RUN, FIN; IDLE -> RUN on accepted start with legal opcode.
REQ-014 On accept (cycle 0) opcode SHALL be latched; iop SHALL be driven from the latched copy from cycle 1 until FIN exit, and 0 otherwise.
REQ-015 In RUN, t SHALL be one-hot, starting T[0] in cycle 1 and advancing one bit per non-stalled cycle to T[7]; t=0 outside RUN.
REQ-016 With stall high, t, iop and all strobes SHALL hold their current values; stall has no effect in IDLE or FIN.
REQ-017 After T[7] (non-stalled), state SHALL go to FIN for exactly one cycle with done=1, t=0, then IDLE.
REQ-018 busy SHALL be 1 in RUN and FIN, 0 in IDLE.
REQ-019 Unstalled latency SHALL be: start accepted cycle 0, T[7] cycle 8, done cycle 9.
REQ-020 ealu and we_lo SHALL be 1 exactly while T[6] is high, for every legal opcode.
REQ-021 For MUL and DIV only, ealu and we_hi SHALL additionally be 1 while T[7] is high (T[6]: product low / quotient; T[7]: product high / remainder).
REQ-022 we_lo and we_hi SHALL never both be 1; ealu SHALL be 0 whenever both are 0.
REQ-023 start SHALL be ignored while busy=1, except in FIN, where a legal start SHALL be accepted and t=T[0] SHALL follow in the next cycle (back-to-back, no idle gap).
REQ-024 Illegal opcode (11-15) at accept: no RUN entry, t/iop/ealu stay 0, err=1 for one cycle in the next cycle, busy stays 0.
REQ-025 DIV with b_zero=1 while T[3] is high (non-stalled) SHALL abort: next cycle t=0, iop=0, no ealu/we strobes, err=1 one cycle, done=0, return to IDLE.
REQ-026 b_zero SHALL be ignored for all opcodes other than DIV and in beats other than T[3].
REQ-027 done and err SHALL never be 1 in the same cycle.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, clearing t, iop, ealu, we_lo, we_hi, busy, done, err and latched opcode to 0, with reset taking priority over start and stall.
REQ-029 Reset asserted mid-operation SHALL abort with no further strobes; first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 ADD (opcode 1), no stall: t=01,02,..,80 in cycles 1-8; iop=0x002; ealu=we_lo=1 only in cycle 7; done=1 cycle 9.
REQ-031 MUL (3): ealu=we_lo=1 at T[6], ealu=we_hi=1 at T[7]; iop=0x008; done cycle 9.
REQ-032 DIV (4) with b_zero=1 in T[3] cycle: err=1 in cycle 5, t=0, no ealu pulse, done never 1; with b_zero=0 behaves as MUL timing with iop=0x010.
REQ-033 SUB with stall high for 3 cycles during T[2]: t holds 0x04 three extra cycles; done in cycle 12.
REQ-034 Opcode 12 start: err=1 next cycle, busy=0, t=0; start held high during an ADD run: second op begins T[0] the cycle after done.
REQ-035 rst pulsed during T[4] of XOR: next cycle all outputs 0, busy=0; subsequent NOT runs with standard latency.

Source files
------------

// File: rtl/alu_seq.sv
// Beat sequencer for a microcoded ALU: runs an 8-beat one-hot ring per accepted opcode
// and drives the op select, ALU output enable and result write strobes.
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic        stall,
    input  logic        b_zero,
    output logic [7:0]  t,
    output logic [10:0] iop,
    output logic        ealu,
    output logic        we_lo,
    output logic        we_hi,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_LAST = 4'd10;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  t_q, t_d;
    logic [10:0] iop_q, iop_d;
    logic        ealu_q, ealu_d;
    logic        we_lo_q, we_lo_d;
    logic        we_hi_q, we_hi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        two_byte_s;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_LAST);
    endfunction

    function automatic logic [10:0] op_onehot(input logic [3:0] op);
        return 11'd1 << op;
    endfunction

    assign two_byte_s = (op_q == OP_MUL) || (op_q == OP_DIV);

    // State and output registers; reset overrides start and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            t_q     <= 8'd0;
            iop_q   <= 11'd0;
            ealu_q  <= 1'b0;
            we_lo_q <= 1'b0;
            we_hi_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            t_q     <= t_d;
            iop_q   <= iop_d;
            ealu_q  <= ealu_d;
            we_lo_q <= we_lo_d;
            we_hi_q <= we_hi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one beat ahead so they register cleanly.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        t_d     = t_q;
        iop_d   = iop_q;
        ealu_d  = ealu_q;
        we_lo_d = we_lo_q;
        we_hi_d = we_hi_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_RUN: begin
                if (stall) begin
                    state_d = S_RUN;
                end else if ((op_q == OP_DIV) && t_q[3] && b_zero) begin
                    state_d = S_IDLE;
                    t_d     = 8'd0;
                    iop_d   = 11'd0;
                    ealu_d  = 1'b0;
                    we_lo_d = 1'b0;
                    we_hi_d = 1'b0;
                    err_d   = 1'b1;
                end else if (t_q[7]) begin
                    // iop stays valid through FIN
                    state_d = S_FIN;
                    t_d     = 8'd0;
                    ealu_d  = 1'b0;
                    we_lo_d = 1'b0;
                    we_hi_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    t_d     = t_q << 1;
                    we_lo_d = t_q[5];
                    we_hi_d = t_q[6] & two_byte_s;
                    ealu_d  = t_q[5] | (t_q[6] & two_byte_s);
                end
            end
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                t_d     = 8'd0;
                iop_d   = 11'd0;
                ealu_d  = 1'b0;
                we_lo_d = 1'b0;
                we_hi_d = 1'b0;
                if (start && op_legal(opcode)) begin
                    state_d = S_RUN;
                    op_d    = opcode;
                    t_d     = 8'd1;
                    iop_d   = op_onehot(opcode);
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                op_d    = 4'd0;
                t_d     = 8'd0;
                iop_d   = 11'd0;
                ealu_d  = 1'b0;
                we_lo_d = 1'b0;
                we_hi_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign t     = t_q;
    assign iop   = iop_q;
    assign ealu  = ealu_q;
    assign we_lo = we_lo_q;
    assign we_hi = we_hi_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver predicts completion cycle and strobe counts
// per operation; a negedge monitor pops and compares on every done/err pulse.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst, start, stall, b_zero;
    logic [3:0]  opcode;
    logic [7:0]  t;
    logic [10:0] iop;
    logic        ealu, we_lo, we_hi, busy, done, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cnt_lo = 0;
    int cnt_hi = 0;

    typedef struct {
        int exp_cyc;
        bit is_err;
        int op;
        int n_lo;
        int n_hi;
    } exp_t;

    exp_t sb[$];

    alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .stall(stall),
        .b_zero(b_zero), .t(t), .iop(iop), .ealu(ealu), .we_lo(we_lo),
        .we_hi(we_hi), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: strobe placement every cycle, scoreboard pop on each completion/error pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cnt_lo = 0;
            cnt_hi = 0;
        end else begin
            if (ealu || we_lo || we_hi) begin
                chk("ealu_vs_we", {31'd0, ealu}, {31'd0, we_lo | we_hi});
                chk("we_exclusive", {31'd0, we_lo & we_hi}, 32'd0);
                if (we_lo) chk("we_lo_beat", {24'd0, t}, 32'h40);
                if (we_hi) chk("we_hi_beat", {24'd0, t}, 32'h80);
            end
            cnt_lo += int'(we_lo);
            cnt_hi += int'(we_hi);
            if (done || err) begin
                chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
                chk("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("end_cycle", cyc, e.exp_cyc);
                    chk("err_flag", {31'd0, err}, {31'd0, e.is_err});
                    chk("done_flag", {31'd0, done}, {31'd0, !e.is_err});
                    chk("t_at_end", {24'd0, t}, 32'd0);
                    chk("busy_at_end", {31'd0, busy}, {31'd0, !e.is_err});
                    chk("iop_at_end", {21'd0, iop}, e.is_err ? 32'd0 : (32'd1 << e.op));
                    chk("we_lo_count", cnt_lo, e.n_lo);
                    chk("we_hi_count", cnt_hi, e.n_hi);
                end
                cnt_lo = 0;
                cnt_hi = 0;
            end
        end
    end

    // One operation from IDLE: stall held for l cycles starting when beat p is shown.
    task automatic run_op(input int op, input int p, input int l, input bit bz);
        exp_t e;
        int   c0, k;
        c0 = cyc;
        opcode = op[3:0];
        start = 1'b1;
        b_zero = (op == 4) ? bz : 1'($urandom_range(0, 1));
        e.op = op;
        if (op > 10) begin
            e.is_err = 1'b1; e.exp_cyc = c0 + 1; e.n_lo = 0; e.n_hi = 0;
        end else if (op == 4 && bz) begin
            e.is_err = 1'b1; e.exp_cyc = c0 + 5 + ((p <= 3) ? l : 0); e.n_lo = 0; e.n_hi = 0;
        end else begin
            e.is_err = 1'b0; e.exp_cyc = c0 + 9 + l; e.n_lo = 1;
            e.n_hi = (op == 3 || op == 4) ? 1 : 0;
        end
        sb.push_back(e);
        tick();
        start = 1'b0;
        while (cyc <= e.exp_cyc) begin
            k = cyc - c0;
            if (!e.is_err && l == 0) begin
                chk("t_beat", {24'd0, t}, (k <= 8) ? (32'd1 << (k - 1)) : 32'd0);
                chk("iop_hold", {21'd0, iop}, 32'd1 << op);
            end
            stall = (k >= p + 1) && (k <= p + l);
            b_zero = (op == 4) ? bz : 1'($urandom_range(0, 1));
            tick();
        end
        stall = 1'b0;
        b_zero = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c0, op, p, l;
        rst = 1'b1; start = 1'b1; opcode = 4'd1; stall = 1'b0; b_zero = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {7'd0, t, iop, ealu, we_lo, we_hi, busy, done, err}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        run_op(1, 0, 0, 1'b0);   // ADD
        run_op(3, 0, 0, 1'b0);   // MUL
        run_op(4, 0, 0, 1'b1);   // DIV by zero -> abort
        run_op(4, 0, 0, 1'b0);   // DIV
        run_op(2, 2, 3, 1'b0);   // SUB stalled on T[2]
        run_op(4, 3, 2, 1'b1);   // DIV by zero with stall on T[3]
        run_op(12, 0, 0, 1'b0);  // illegal
        chk("illegal_busy", {31'd0, busy}, 32'd0);

        // start held through an ADD run; opcode changes mid-run must not disturb it
        c0 = cyc;
        opcode = 4'd1; start = 1'b1;
        e.exp_cyc = c0 + 9;  e.is_err = 1'b0; e.op = 1; e.n_lo = 1; e.n_hi = 0; sb.push_back(e);
        e.exp_cyc = c0 + 18; e.is_err = 1'b0; e.op = 2; e.n_lo = 1; e.n_hi = 0; sb.push_back(e);
        tick();
        opcode = 4'd2;
        while (cyc < c0 + 9) tick();
        tick();
        start = 1'b0;
        chk("b2b_t0", {24'd0, t}, 32'h01);
        chk("b2b_iop", {21'd0, iop}, 32'h004);
        while (cyc <= c0 + 18) tick();

        // reset during T[4] of XOR
        c0 = cyc;
        opcode = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c0 + 5) tick();
        chk("xor_t4", {24'd0, t}, 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_reset", {7'd0, t, iop, ealu, we_lo, we_hi, busy, done, err}, 32'd0);
        run_op(6, 0, 0, 1'b0);   // NOT

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 5) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
            p  = $urandom_range(0, 7);
            l  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            run_op(op, p, l, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
